// File: rtl/ahb_mem.sv
// ahb_mem: AHB-Lite slave SRAM with byte-lane writes and configurable wait
// states.
// Optional feature macro: AHB_MEM_ERROR_EN (two-cycle ERROR response for
// misaligned / HSIZE>2 accesses; when undefined such accesses are aligned
// down and treated as word).
`timescale 1ns/1ps
module ahb_mem #(
  parameter int    ADDR_WIDTH  = 16,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int WW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << WW;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            accept, bad, rd_acc, commit;
  logic [3:0]      lane;
  logic [WW-1:0]   a_idx, w_idx;
  logic [3:0]      w_mask, fwd_mask;
  logic            wr_pend, rd_zero;
  logic [31:0]     rd_raw, fwd_data;
  logic            unused_ok;

  logic [31:0] mem [DEPTH];

  assign unused_ok = HTRANS[0];
  assign a_idx     = HADDR[ADDR_WIDTH-1:2];
  assign accept    = HSEL & HTRANS[1] & HREADY & HREADYOUT;
  assign rd_acc    = accept & ~HWRITE & ~bad;
  assign commit    = (state == S_LAST) & wr_pend;

`ifdef AHB_MEM_ERROR_EN
  assign bad   = ((HSIZE == 3'd1) & HADDR[0]) | ((HSIZE == 3'd2) & (|HADDR[1:0])) |
                 (HSIZE > 3'd2);
  assign HRESP = (state == S_ERR1) | (state == S_ERR2);
`else
  assign bad   = 1'b0;
  assign HRESP = 1'b0;
`endif

  assign HREADYOUT = ~((state == S_WAIT) | (state == S_ERR1));

  always_comb begin
    lane = 4'hF;
    case (HSIZE)
      3'd0:    lane = 4'b0001 << HADDR[1:0];
      3'd1:    lane = HADDR[1] ? 4'b1100 : 4'b0011;
      default: lane = 4'hF;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_WAIT: begin
        if (cnt == 4'd0) state_nx = S_LAST;
        else             cnt_nx   = cnt - 4'd1;
      end
      S_ERR1: state_nx = S_ERR2;
      default: begin
        if (accept) begin
          if (bad) state_nx = S_ERR1;
          else if (WAIT_STATES > 0) begin
            state_nx = S_WAIT;
            cnt_nx   = WS_LOAD;
          end else state_nx = S_LAST;
        end else state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      wr_pend  <= 1'b0;
      w_idx    <= '0;
      w_mask   <= 4'd0;
      rd_zero  <= 1'b1;
      fwd_mask <= 4'd0;
      fwd_data <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        wr_pend <= HWRITE & ~bad;
        w_idx   <= a_idx;
        w_mask  <= lane;
      end else if (commit) begin
        wr_pend <= 1'b0;
      end
      if (rd_acc) begin
        rd_zero  <= 1'b0;
        fwd_mask <= (commit && (w_idx == a_idx)) ? w_mask : 4'd0;
        fwd_data <= HWDATA;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++)
        if (w_mask[i]) mem[w_idx][8*i +: 8] <= HWDATA[8*i +: 8];
    end
    if (rd_acc) rd_raw <= mem[a_idx];
  end

  always_comb begin
    HRDATA = 32'd0;
    if (!rd_zero)
      for (int i = 0; i < 4; i++)
        HRDATA[8*i +: 8] = fwd_mask[i] ? fwd_data[8*i +: 8] : rd_raw[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_mem.sv
// tb_ahb_mem: scoreboard bench for ahb_mem with a zero-wait and a
// three-wait-state instance sharing one address/data bus.
`timescale 1ns/1ps
module tb_ahb_mem;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0, write = 1'b0, cur = 1'b0;
  logic [1:0]  trans = 2'b00;
  logic [15:0] addr = 16'd0;
  logic [2:0]  size = 3'd0;
  logic [31:0] wdata = 32'd0;

  logic        sel0, sel3, rdy0, rdy3, resp0, resp3;
  logic [31:0] rd0, rd3;
  logic        m_ready, m_resp;
  logic [31:0] m_rdata;
  assign sel0    = sel & ~cur;
  assign sel3    = sel & cur;
  assign m_ready = cur ? rdy3 : rdy0;
  assign m_resp  = cur ? resp3 : resp0;
  assign m_rdata = cur ? rd3 : rd0;

  ahb_mem #(.ADDR_WIDTH(16), .WAIT_STATES(0), .INIT_FILE("")) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(addr), .HTRANS(trans),
    .HWRITE(write), .HSIZE(size), .HWDATA(wdata), .HREADY(rdy0),
    .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(resp0));

  ahb_mem #(.ADDR_WIDTH(16), .WAIT_STATES(3), .INIT_FILE("")) u3 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HADDR(addr), .HTRANS(trans),
    .HWRITE(write), .HSIZE(size), .HWDATA(wdata), .HREADY(rdy3),
    .HRDATA(rd3), .HREADYOUT(rdy3), .HRESP(resp3));

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          checks = 0, failures = 0;
  logic [31:0] last_rd [2];
  logic        inph = 1'b0;
  int          mwaits = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One transfer: present address phase, wait for acceptance, then drive its
  // write data and queue the expected data-phase response.
  task automatic xfer(input logic s, input logic [1:0] tr, input logic wr,
                      input logic [15:0] a, input logic [2:0] sz, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee, input int ew);
    exp_t e;
    int   n;
    sel = s; trans = tr; write = wr; addr = a; size = sz;
    n = 0;
    while (!m_ready && n < 50) begin @(posedge clk); @(negedge clk); n++; end
    if (n >= 50) chk("ready_timeout", {31'd0, m_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    if (s && tr[1]) begin
      if (wr) wdata = wd;
      e.rd = ~wr; e.err = ee; e.waits = ew;
      if (wr || ee) e.data = last_rd[cur];
      else begin e.data = ed; last_rd[cur] = ed; end
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int extra);
    int n;
    sel = 1'b0; trans = 2'b00; write = 1'b0;
    n = 0;
    while (!m_ready && n < 50) begin @(posedge clk); @(negedge clk); n++; end
    if (n >= 50) chk("idle_timeout", {31'd0, m_ready}, 32'd1);
    repeat (extra + 1) begin @(posedge clk); @(negedge clk); end
  endtask

  // Monitor: follows data phases from bus signals and checks each completion.
  always begin
    @(negedge clk); #2;
    if (rst) begin
      inph = 1'b0; mwaits = 0; sb.delete();
    end else begin
      if (inph) begin
        if (!m_ready) begin
          mwaits++;
          if (sb.size() > 0) chk("resp_wait", {31'd0, m_resp}, {31'd0, sb[0].err});
        end else begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_underflow actual=completion expected=none");
          end else begin
            me = sb.pop_front();
            chk(me.rd ? "rd_waits" : "wr_waits", mwaits, me.waits);
            chk("resp", {31'd0, m_resp}, {31'd0, me.err});
            chk(me.rd ? "rdata" : "rdata_hold", m_rdata, me.data);
          end
          inph = 1'b0;
        end
      end
      if (sel && trans[1] && m_ready) begin inph = 1'b1; mwaits = 0; end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  localparam logic [1:0] NS = 2'b10, BUSY = 2'b01;
  localparam logic [2:0] B = 3'd0, H = 3'd1, W = 3'd2;
`ifdef AHB_MEM_ERROR_EN
  localparam logic        ERR_EN = 1'b1;
  localparam logic [31:0] MIS_RD = 32'h1234_5678;
`else
  localparam logic        ERR_EN = 1'b0;
  localparam logic [31:0] MIS_RD = 32'hCAFE_F00D;
`endif

  initial begin
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ready0", {31'd0, rdy0}, 32'd1);
    chk("rst_resp0", {31'd0, resp0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_ready3", {31'd0, rdy3}, 32'd1);
    chk("rst_resp3", {31'd0, resp3}, 32'd0);
    chk("rst_rdata3", rd3, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // zero-wait instance
    cur = 1'b0;
    xfer(1, NS, 1, 16'h0010, W, 32'hDEAD_BEEF, 0, 0, 0);
    xfer(1, NS, 0, 16'h0010, W, 0, 32'hDEAD_BEEF, 0, 0);
    xfer(1, NS, 1, 16'h0012, B, 32'h11AA_2233, 0, 0, 0);
    xfer(1, NS, 0, 16'h0010, W, 0, 32'hDEAA_BEEF, 0, 0);
    idle(1);
    xfer(1, NS, 0, 16'h0010, W, 0, 32'hDEAA_BEEF, 0, 0);
    xfer(1, NS, 1, 16'h0014, W, 32'hA5A5_A5A5, 0, 0, 0);
    xfer(1, NS, 1, 16'h0016, H, 32'hBEEF_1234, 0, 0, 0);
    xfer(1, NS, 1, 16'h0014, H, 32'h9999_CAFE, 0, 0, 0);
    xfer(1, NS, 0, 16'h0014, W, 0, 32'hBEEF_CAFE, 0, 0);
    xfer(1, NS, 1, 16'h0011, B, 32'h0000_7700, 0, 0, 0);
    xfer(1, NS, 0, 16'h0010, W, 0, 32'hDEAA_77EF, 0, 0);
    xfer(0, NS, 1, 16'h0010, W, 32'hFFFF_FFFF, 0, 0, 0);
    xfer(1, BUSY, 1, 16'h0010, W, 32'hFFFF_FFFF, 0, 0, 0);
    idle(1);
    xfer(1, NS, 0, 16'h0010, W, 0, 32'hDEAA_77EF, 0, 0);
    xfer(1, NS, 1, 16'h0020, W, 32'h1234_5678, 0, 0, 0);
    xfer(1, NS, 0, 16'h0020, W, 0, 32'h1234_5678, 0, 0);
    xfer(1, NS, 1, 16'h0022, W, 32'hCAFE_F00D, 0, ERR_EN, ERR_EN ? 1 : 0);
    xfer(1, NS, 0, 16'h0020, W, 0, MIS_RD, 0, 0);
    xfer(1, NS, 1, 16'hFFFC, W, 32'h0BAD_C0DE, 0, 0, 0);
    idle(1);
    xfer(1, NS, 0, 16'hFFFC, W, 0, 32'h0BAD_C0DE, 0, 0);
    idle(2);

    // three-wait-state instance
    cur = 1'b1;
    xfer(1, NS, 1, 16'h0030, W, 32'h5A5A_5A5A, 0, 0, 3);
    xfer(1, NS, 0, 16'h0030, W, 0, 32'h5A5A_5A5A, 0, 3);
    // a write presented while HREADYOUT is low must be ignored
    sel = 1'b1; write = 1'b1; trans = NS; addr = 16'h0030; size = W;
    wdata = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    idle(2);
    xfer(1, NS, 0, 16'h0030, W, 0, 32'h5A5A_5A5A, 0, 3);
    xfer(1, NS, 1, 16'h0040, W, 32'h1111_1111, 0, 0, 3);
    idle(1);
    // write aborted by reset while in its wait states
    sel = 1'b1; write = 1'b1; trans = NS; addr = 16'h0040; size = W;
    @(posedge clk); @(negedge clk);
    wdata = 32'h2222_2222; sel = 1'b0; trans = 2'b00; write = 1'b0;
    @(posedge clk); @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, rdy3}, 32'd1);
    chk("arst_resp", {31'd0, resp3}, 32'd0);
    chk("arst_rdata", rd3, 32'd0);
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    xfer(1, NS, 0, 16'h0040, W, 0, 32'h1111_1111, 0, 3);
    idle(3);

    chk("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
